// File: rtl/mux_scan_pkg.sv
// Shared definitions for the 74x251 mux-bank scanner.
package mux_scan_pkg;

  // Select positions on one '251 and the width of the select bus.
  localparam int unsigned MUX_POSITIONS = 8;
  localparam int unsigned SEL_W         = 3;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StCompare
  } state_t;

endpackage

// File: rtl/mux_scan_debounce.sv
// Sweep-to-sweep debounce plus the valid/ack publish register for the scanner.
module mux_scan_debounce #(
  parameter int unsigned Width    = 16,
  parameter int unsigned Debounce = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             compare_i,
  input  logic             abort_i,
  input  logic [Width-1:0] word_i,
  input  logic             ack_i,
  output logic [Width-1:0] data_o,
  output logic             valid_o,
  output logic             overrun_o
);

  localparam int unsigned CntW = $clog2(Debounce + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(Debounce);

  logic [Width-1:0] prev_q, prev_d;
  logic [Width-1:0] data_q, data_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [CntW-1:0]  cnt_upd;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             first_q, first_d;
  logic             publish;

  // Next-state for the stable counter, publish decision and the handshake.
  always_comb begin
    prev_d  = prev_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    first_d = first_q;

    if (word_i == prev_q) begin
      cnt_upd = (cnt_q >= CntMax) ? CntMax : cnt_q + CntW'(1);
    end else begin
      cnt_upd = CntW'(1);
    end
    publish = compare_i && (cnt_upd == CntMax) && ((word_i != data_q) || first_q);

    if (valid_q && ack_i) begin
      valid_d = 1'b0;
    end

    if (compare_i) begin
      prev_d = word_i;
      cnt_d  = cnt_upd;
    end

    if (publish) begin
      // Acked in this same cycle counts as free; otherwise the word is lost,
      // but the counter stays saturated so it republishes after the ack.
      if (!valid_q || ack_i) begin
        data_d  = word_i;
        valid_d = 1'b1;
        first_d = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end

    if (abort_i) begin
      cnt_d = '0;
    end
  end

  // Debounce and publish state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      first_q <= 1'b1;
    end else begin
      prev_q  <= prev_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      first_q <= first_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/mux_scan_reader.sv
// Scans a bank of 74x251 muxes, assembles one word per sweep and hands it to
// the debounce/publish stage.
module mux_scan_reader
  import mux_scan_pkg::*;
#(
  parameter int unsigned NUM_MUX  = 2,
  parameter int unsigned SETTLE   = 2,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             run,
  output logic [SEL_W-1:0]                 mux_sel,
  output logic                             mux_ne,
  input  logic [NUM_MUX-1:0]               mux_y,
  output logic [MUX_POSITIONS*NUM_MUX-1:0] data,
  output logic                             valid,
  input  logic                             ack,
  output logic                             overrun,
  output logic                             sweep_done
);

  localparam int unsigned WordW = MUX_POSITIONS * NUM_MUX;
  localparam int unsigned WaitW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(SETTLE - 1);
  localparam logic [SEL_W-1:0] SelLast  = SEL_W'(MUX_POSITIONS - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             ne_q, ne_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [WordW-1:0] sweep_q, sweep_d;
  logic             compare;
  logic             abort;

  // Sweep FSM: settle, sample, advance select, compare at end of sweep.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ne_d    = ne_q;
    wait_d  = wait_q;
    sweep_d = sweep_q;
    compare = 1'b0;
    abort   = 1'b0;

    unique case (state_q)
      StIdle: begin
        sel_d = '0;
        ne_d  = 1'b1;
        if (run) begin
          state_d = StSettle;
          ne_d    = 1'b0;
          wait_d  = '0;
        end
      end
      StSettle: begin
        if (!run) begin
          abort = 1'b1;
        end else if (wait_q == WaitLast) begin
          state_d = StSample;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StSample: begin
        if (!run) begin
          abort = 1'b1;
        end else begin
          for (int b = 0; b < NUM_MUX; b++) begin
            sweep_d[b*MUX_POSITIONS + int'(sel_q)] = mux_y[b];
          end
          wait_d = '0;
          if (sel_q == SelLast) begin
            state_d = StCompare;
            sel_d   = '0;
          end else begin
            state_d = StSettle;
            sel_d   = sel_q + SEL_W'(1);
          end
        end
      end
      StCompare: begin
        compare = 1'b1;
        wait_d  = '0;
        if (run) begin
          state_d = StSettle;
        end else begin
          state_d = StIdle;
          ne_d    = 1'b1;
          sel_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        ne_d    = 1'b1;
        sel_d   = '0;
      end
    endcase

    // A dropped run discards the partial sweep; the buffer is fully
    // rewritten by the next sweep so it needs no clearing.
    if (abort) begin
      state_d = StIdle;
      sel_d   = '0;
      ne_d    = 1'b1;
    end
  end

  // FSM, mux drive and sweep buffer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      sel_q   <= '0;
      ne_q    <= 1'b1;
      wait_q  <= '0;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ne_q    <= ne_d;
      wait_q  <= wait_d;
      sweep_q <= sweep_d;
    end
  end

  assign mux_sel    = sel_q;
  assign mux_ne     = ne_q;
  assign sweep_done = (state_q == StCompare);

  mux_scan_debounce #(
    .Width    (WordW),
    .Debounce (DEBOUNCE)
  ) u_debounce (
    .clk_i     (clk),
    .rst_i     (reset),
    .compare_i (compare),
    .abort_i   (abort),
    .word_i    (sweep_q),
    .ack_i     (ack),
    .data_o    (data),
    .valid_o   (valid),
    .overrun_o (overrun)
  );

endmodule

// File: tb/tb_mux_scan_reader.sv
// Bench for mux_scan_reader: directed sweep table, hand-written corner
// sequences and a random phase against a sweep-level reference model.
module tb_mux_scan_reader;

  localparam int unsigned NUM_MUX  = 2;
  localparam int unsigned SETTLE   = 2;
  localparam int unsigned DEBOUNCE = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        ack;
  logic [2:0]  mux_sel;
  logic        mux_ne;
  logic [1:0]  mux_y;
  logic [15:0] data;
  logic        valid;
  logic        overrun;
  logic        sweep_done;

  logic [15:0] cur_word;
  int          total = 0;
  int          bad   = 0;

  // Sweep-level reference model state.
  logic [15:0] hist[$];
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ovr;
  logic        m_first;

  typedef struct {
    logic [15:0] word;
    logic        ack;
    logic        ev;
    logic [15:0] ed;
    logic        eo;
  } vec_t;

  vec_t tbl[18];

  mux_scan_reader #(
    .NUM_MUX  (NUM_MUX),
    .SETTLE   (SETTLE),
    .DEBOUNCE (DEBOUNCE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .mux_sel    (mux_sel),
    .mux_ne     (mux_ne),
    .mux_y      (mux_y),
    .data       (data),
    .valid      (valid),
    .ack        (ack),
    .overrun    (overrun),
    .sweep_done (sweep_done)
  );

  always #5 clk = ~clk;

  // '251 model: y follows the selected input, forced low while disabled.
  always_comb begin
    mux_y = '0;
    for (int b = 0; b < NUM_MUX; b++) begin
      mux_y[b] = mux_ne ? 1'b0 : cur_word[b*8 + int'(mux_sel)];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic ev, input logic [15:0] ed,
                            input logic eo);
    check({name, " valid"}, 32'(valid), 32'(ev));
    check({name, " data"}, 32'(data), 32'(ed));
    check({name, " overrun"}, 32'(overrun), 32'(eo));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    run   = 1'b0;
    ack   = 1'b0;
    #1;
    check("reset mux_sel", 32'(mux_sel), 32'd0);
    check("reset mux_ne", 32'(mux_ne), 32'd1);
    check("reset sweep_done", 32'(sweep_done), 32'd0);
    check_outs("reset", 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Run one full sweep with word w held and ack held at a; returns just
  // after the compare edge.
  task automatic do_sweep(input logic [15:0] w, input logic a);
    bit found;
    cur_word = w;
    ack      = a;
    run      = 1'b1;
    found    = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk);
      #1;
      if (sweep_done) found = 1'b1;
    end
    check("sweep_done within bound", 32'(found), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Model: a word is stable once DEBOUNCE consecutive sweeps agree.
  task automatic model_sweep(input logic [15:0] w, input logic a);
    bit stable;
    hist.push_back(w);
    if (hist.size() > DEBOUNCE) hist.delete(0);
    stable = (hist.size() == DEBOUNCE);
    foreach (hist[i]) if (hist[i] != w) stable = 1'b0;
    if (a) m_valid = 1'b0;
    if (stable && (w != m_data || m_first)) begin
      if (!m_valid) begin
        m_data  = w;
        m_valid = 1'b1;
        m_first = 1'b0;
      end else begin
        m_ovr = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_first = 1'b1;
  endtask

  initial begin
    logic [15:0] w;
    logic [15:0] pool[3];
    logic        a;
    logic        exp_sd;
    logic [2:0]  exp_sel;
    bit          hit;

    reset    = 1'b1;
    run      = 1'b0;
    ack      = 1'b0;
    cur_word = '0;

    tbl[0]  = '{16'hA55A, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[1]  = '{16'hA55A, 1'b0, 1'b0, 16'h0000, 1'b0};
    tbl[2]  = '{16'hA55A, 1'b0, 1'b1, 16'hA55A, 1'b0};
    tbl[3]  = '{16'hA55A, 1'b1, 1'b0, 16'hA55A, 1'b0};
    tbl[4]  = '{16'h0001, 1'b0, 1'b0, 16'hA55A, 1'b0};
    tbl[5]  = '{16'h0002, 1'b0, 1'b0, 16'hA55A, 1'b0};
    tbl[6]  = '{16'h0001, 1'b0, 1'b0, 16'hA55A, 1'b0};
    tbl[7]  = '{16'h0002, 1'b0, 1'b0, 16'hA55A, 1'b0};
    tbl[8]  = '{16'h0002, 1'b0, 1'b0, 16'hA55A, 1'b0};
    tbl[9]  = '{16'h0002, 1'b0, 1'b1, 16'h0002, 1'b0};
    tbl[10] = '{16'h1234, 1'b1, 1'b0, 16'h0002, 1'b0};
    tbl[11] = '{16'h1234, 1'b0, 1'b0, 16'h0002, 1'b0};
    tbl[12] = '{16'h1234, 1'b0, 1'b1, 16'h1234, 1'b0};
    tbl[13] = '{16'h4321, 1'b0, 1'b1, 16'h1234, 1'b0};
    tbl[14] = '{16'h4321, 1'b0, 1'b1, 16'h1234, 1'b0};
    tbl[15] = '{16'h4321, 1'b0, 1'b1, 16'h1234, 1'b1};
    tbl[16] = '{16'h4321, 1'b1, 1'b1, 16'h4321, 1'b1};
    tbl[17] = '{16'h4321, 1'b1, 1'b0, 16'h4321, 1'b1};

    // Cycle-exact timing of the first three sweeps.
    do_reset();
    @(posedge clk);
    #1;
    run      = 1'b1;
    cur_word = 16'hA55A;
    for (int k = 0; k <= 75; k++) begin
      @(posedge clk);
      #1;
      exp_sd  = ((k % 25) == 24);
      exp_sel = exp_sd ? 3'd0 : 3'((k % 25) / 3);
      check($sformatf("scan cycle %0d", k), {26'd0, mux_sel, mux_ne, sweep_done, valid},
            {26'd0, exp_sel, 1'b0, exp_sd, (k == 75)});
    end
    check("first publish data", 32'(data), 32'h0000A55A);
    ack = 1'b1;
    @(posedge clk);
    #1;
    check("ack clears valid", 32'(valid), 32'd0);
    ack = 1'b0;

    // Directed sweep table.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      do_sweep(tbl[i].word, tbl[i].ack);
      check_outs($sformatf("table row %0d", i), tbl[i].ev, tbl[i].ed, tbl[i].eo);
    end

    // Drop run at position 4, then resume: three fresh sweeps needed.
    do_sweep(16'h5A5A, 1'b0);
    check_outs("pre-abort", 1'b0, 16'h4321, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      if (mux_sel == 3'd4) hit = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("reached mux_sel 4", 32'(hit), 32'd1);
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("idle after abort %0d", i), {29'd0, mux_sel, mux_ne, sweep_done},
            {29'd0, 3'd0, 1'b1, 1'b0});
    end
    do_sweep(16'h5A5A, 1'b0);
    check_outs("resume sweep 1", 1'b0, 16'h4321, 1'b1);
    do_sweep(16'h5A5A, 1'b0);
    check_outs("resume sweep 2", 1'b0, 16'h4321, 1'b1);
    do_sweep(16'h5A5A, 1'b0);
    check_outs("resume sweep 3", 1'b1, 16'h5A5A, 1'b1);

    // Reset during SAMPLE at position 3 with valid pending.
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      if (mux_sel == 3'd3) hit = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("reached mux_sel 3", 32'(hit), 32'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid-sweep reset sel/ne", {30'd0, mux_sel[0], mux_ne}, {30'd0, 1'b0, 1'b1});
    check("mid-sweep reset mux_sel", 32'(mux_sel), 32'd0);
    check_outs("mid-sweep reset", 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    do_sweep(16'h0000, 1'b0);
    check_outs("zero sweep 1", 1'b0, 16'h0000, 1'b0);
    do_sweep(16'h0000, 1'b0);
    check_outs("zero sweep 2", 1'b0, 16'h0000, 1'b0);
    do_sweep(16'h0000, 1'b0);
    check_outs("zero first publish", 1'b1, 16'h0000, 1'b0);

    // Random sweeps against the reference model, with occasional aborts.
    do_reset();
    model_reset();
    pool[0] = 16'h00FF;
    pool[1] = 16'hBEEF;
    pool[2] = 16'h0000;
    w = pool[0];
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0 && n > 0) begin
        ack = 1'b0;
        repeat ($urandom_range(1, 20)) begin
          @(posedge clk);
          #1;
        end
        run = 1'b0;
        @(posedge clk);
        #1;
        check($sformatf("random abort %0d idle", n), {30'd0, mux_ne, sweep_done},
              {30'd0, 1'b1, 1'b0});
        hist.delete();
      end
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: w = w;
        9:                w = 16'($urandom);
        default:          w = pool[$urandom_range(0, 2)];
      endcase
      a = ($urandom_range(0, 2) == 0);
      do_sweep(w, a);
      model_sweep(w, a);
      check_outs($sformatf("random sweep %0d", n), m_valid, m_data, m_ovr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
